// File: rtl/cpu_data_responder.sv
// Data-side responder: word RAM plus MMIO timer and console TX FIFO.
// Timer block is built only with CPU_DATA_RESPONDER_TIMER_EN defined.
module cpu_data_responder #(
  parameter int          DEPTH      = 1024,
  parameter int          FIFO_DEPTH = 16,
  parameter int          PRESCALE   = 1,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic [31:0] read_addr,
  output logic [31:0] read_data,
  input  logic        wr_en,
  input  logic [31:0] write_addr,
  input  logic [31:0] wr_data,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready,
  output logic        timer_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FIFO_DEPTH);

  localparam logic [7:0] OFF_MTL = 8'h00;
  localparam logic [7:0] OFF_MTH = 8'h04;
  localparam logic [7:0] OFF_MCL = 8'h08;
  localparam logic [7:0] OFF_MCH = 8'h0C;
  localparam logic [7:0] OFF_TX  = 8'h10;
  localparam logic [7:0] OFF_ST  = 8'h14;
  localparam logic [7:0] OFF_DRP = 8'h18;

  logic r_ram;
  logic r_mmio;
  logic w_ram;
  logic w_mmio;
  logic [7:0] roff;
  logic [7:0] woff;

  assign r_ram  = read_addr[31:AW+2] == '0;
  assign r_mmio = read_addr[31:16] == MMIO_BASE[31:16];
  assign w_ram  = wr_en && (write_addr[31:AW+2] == '0);
  assign w_mmio = wr_en && (write_addr[31:16] == MMIO_BASE[31:16]);
  assign roff   = read_addr[7:0];
  assign woff   = write_addr[7:0];

  logic [31:0] mem [DEPTH];

  // RAM store port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_ram) mem[write_addr[AW+1:2]] <= wr_data;
  end

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] head;
  logic [FW-1:0] tail;
  logic [FW:0]   count;
  logic [31:0]   drops;
  logic          full;
  logic          empty;
  logic          tx_wr;
  logic          push;
  logic          drop;
  logic          pop;
  logic [8:0]    cnt9;

  assign full  = count == (FW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign tx_wr = w_mmio && (woff == OFF_TX);
  assign push  = tx_wr && !full;
  assign drop  = tx_wr && full;
  assign pop   = !empty && console_ready;
  assign cnt9  = 9'(count);

  assign console_valid = !empty;
  assign console_data  = empty ? 8'h00 : fifo_mem[head];

  // FIFO storage write at the tail
  always_ff @(posedge clk) begin
    if (push) fifo_mem[tail] <= wr_data[7:0];
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      drops <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && drops != 32'hFFFF_FFFF)
        drops <= drops + 32'd1;
    end
  end

  logic [31:0] tmr_rdata;

`ifdef CPU_DATA_RESPONDER_TIMER_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] pre;
  logic        irq_q;
  logic        tick;
  logic        lo_we;
  logic        hi_we;
  logic        cl_we;
  logic        ch_we;

  assign tick  = pre == 32'(PRESCALE - 1);
  assign lo_we = w_mmio && (woff == OFF_MTL);
  assign hi_we = w_mmio && (woff == OFF_MTH);
  assign cl_we = w_mmio && (woff == OFF_MCL);
  assign ch_we = w_mmio && (woff == OFF_MCH);
  assign timer_irq = irq_q;

  // Prescaled 64-bit mtime; CPU writes override the tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime    <= '0;
      mtimecmp <= '1;
      pre      <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (lo_we || hi_we || tick) pre <= '0;
      else pre <= pre + 32'd1;
      if (lo_we || hi_we) begin
        if (lo_we) mtime[31:0]  <= wr_data;
        if (hi_we) mtime[63:32] <= wr_data;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (cl_we) mtimecmp[31:0]  <= wr_data;
      if (ch_we) mtimecmp[63:32] <= wr_data;
      irq_q <= mtime >= mtimecmp;
    end
  end

  // Timer register read mux
  always_comb begin
    tmr_rdata = '0;
    unique case (roff)
      OFF_MTL: tmr_rdata = mtime[31:0];
      OFF_MTH: tmr_rdata = mtime[63:32];
      OFF_MCL: tmr_rdata = mtimecmp[31:0];
      OFF_MCH: tmr_rdata = mtimecmp[63:32];
      default: tmr_rdata = '0;
    endcase
  end
`else
  assign timer_irq = 1'b0;
  assign tmr_rdata = '0;
`endif

  logic [31:0] status;
  logic [31:0] mmio_rd;

  assign status = {16'h0, cnt9[7:0], 5'b0, timer_irq, empty, full};

  // MMIO read mux
  always_comb begin
    mmio_rd = '0;
    unique case (roff)
      OFF_MTL, OFF_MTH,
      OFF_MCL, OFF_MCH: mmio_rd = tmr_rdata;
      OFF_ST:           mmio_rd = status;
      OFF_DRP:          mmio_rd = drops;
      default:          mmio_rd = '0;
    endcase
  end

  // Zero-latency load data select
  always_comb begin
    read_data = '0;
    if (rd_en) begin
      unique case (1'b1)
        r_ram:   read_data = mem[read_addr[AW+1:2]];
        r_mmio:  read_data = mmio_rd;
        default: read_data = '0;
      endcase
    end
  end

  logic unused;
  assign unused = ^{read_addr[1:0], read_addr[15:8],
                    write_addr[1:0], write_addr[15:8], cnt9[8]};

endmodule

// File: tb/tb_cpu_data_responder.sv
// Directed bench for cpu_data_responder.
// Timer checks run only when CPU_DATA_RESPONDER_TIMER_EN is defined.
module tb_cpu_data_responder;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        wr_en;
  logic [31:0] write_addr;
  logic [31:0] wr_data;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
  logic        timer_irq;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] v;

  cpu_data_responder dut (
    .clk(clk), .rst(rst),
    .rd_en(rd_en), .read_addr(read_addr), .read_data(read_data),
    .wr_en(wr_en), .write_addr(write_addr), .wr_data(wr_data),
    .console_valid(console_valid), .console_data(console_data),
    .console_ready(console_ready), .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1;
    write_addr = a;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    rd_en = 1'b1;
    read_addr = a;
    #1;
    d = read_data;
    rd_en = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    read_addr = '0;
    write_addr = '0;
    wr_data = '0;
    console_ready = 1'b0;
    #12 rst = 1'b1;
    step(1);

    chk("rst_valid", 32'(console_valid), 32'd0);
    chk("rst_irq", 32'(timer_irq), 32'd0);
    chk("rst_cdata", 32'(console_data), 32'd0);
    chk("idle_rdata", read_data, 32'd0);
    rd(MB + 32'h14, v); chk("rst_status", v, 32'h0000_0002);
    rd(MB + 32'h18, v); chk("rst_drop", v, 32'd0);

    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h12, v); chk("ram_rd", v, 32'hDEAD_BEEF);
    rd_en = 1'b1;
    read_addr = 32'h10;
    wr_en = 1'b1;
    write_addr = 32'h10;
    wr_data = 32'h1;
    #1;
    chk("ram_rw_old", read_data, 32'hDEAD_BEEF);
    step(1);
    rd_en = 1'b0;
    wr_en = 1'b0;
    rd(32'h10, v); chk("ram_rw_new", v, 32'h1);
    rd(32'h0001_0000, v); chk("unmapped", v, 32'd0);
    wr(32'h0001_0000, 32'h55);
    rd(32'h0, v); chk("unmapped_wr", v === 32'h55 ? 32'd1 : 32'd0, 32'd0);
    rd(MB + 32'h40, v); chk("mmio_unlisted", v, 32'd0);
    rd(MB + 32'h10, v); chk("tx_rd", v, 32'd0);

`ifdef CPU_DATA_RESPONDER_TIMER_EN
    rd(MB + 32'h08, v); chk("cmp_lo_rst", v, 32'hFFFF_FFFF);
    wr(MB + 32'h00, 32'hFFFF_FFFE);
    wr(MB + 32'h04, 32'h0);
    rd(MB + 32'h00, v); chk("mt_lo_set", v, 32'hFFFF_FFFE);
    rd(MB + 32'h04, v); chk("mt_hi_set", v, 32'h0);
    step(2);
    rd(MB + 32'h04, v); chk("mt_hi_carry", v, 32'h1);
    rd(MB + 32'h00, v); chk("mt_lo_carry", v, 32'h0);
    chk("irq_big_cmp", 32'(timer_irq), 32'd0);
    wr(MB + 32'h04, 32'h0);
    wr(MB + 32'h00, 32'h0);
    wr(MB + 32'h0C, 32'h0);
    wr(MB + 32'h08, 32'h5);
    step(3);
    rd(MB + 32'h00, v); chk("mt_at5", v, 32'h5);
    chk("irq_pre", 32'(timer_irq), 32'd0);
    step(1);
    chk("irq_rise", 32'(timer_irq), 32'd1);
    rd(MB + 32'h14, v); chk("status_irq", v, 32'h0000_0006);
`else
    wr(MB + 32'h00, 32'h1234);
    step(100);
    rd(MB + 32'h00, v); chk("mt_off_lo", v, 32'd0);
    rd(MB + 32'h08, v); chk("cmp_off_lo", v, 32'd0);
    chk("irq_off", 32'(timer_irq), 32'd0);
`endif

    for (int i = 0; i < 17; i++) wr(MB + 32'h10, 32'(8'h41 + i));
    rd(MB + 32'h14, v); chk("fill_status", v, 32'h0000_1001);
    rd(MB + 32'h18, v); chk("fill_drop", v, 32'd1);
    console_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(console_valid), 32'd1);
      chk("drain_data", 32'(console_data), 32'(8'h41 + i));
      step(1);
    end
    console_ready = 1'b0;
    chk("drained_valid", 32'(console_valid), 32'd0);
    rd(MB + 32'h14, v); chk("drained_empty", 32'(v[1]), 32'd1);

    for (int i = 0; i < 16; i++) wr(MB + 32'h10, 32'(8'h61 + i));
    console_ready = 1'b1;
    wr(MB + 32'h10, 32'h5A);
    console_ready = 1'b0;
    rd(MB + 32'h14, v); chk("full_pop_cnt", v[15:0], 32'h0F00);
    rd(MB + 32'h18, v); chk("full_pop_drop", v, 32'd2);
    chk("full_pop_head", 32'(console_data), 32'h62);
    console_ready = 1'b1;
    step(12);
    console_ready = 1'b0;
    rd(MB + 32'h14, v); chk("three_left", v[15:0], 32'h0300);
    console_ready = 1'b1;
    wr(MB + 32'h10, 32'h59);
    console_ready = 1'b0;
    rd(MB + 32'h14, v); chk("pushpop_cnt", v[15:0], 32'h0300);
    chk("pushpop_head", 32'(console_data), 32'h6F);

    wr(MB + 32'h10, 32'h31);
    wr(MB + 32'h10, 32'h32);
    rd(MB + 32'h14, v); chk("five_q", v[15:0], 32'h0500);
`ifdef CPU_DATA_RESPONDER_TIMER_EN
    chk("irq_before_rst", 32'(timer_irq), 32'd1);
`endif
    #3 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(console_valid), 32'd0);
    chk("arst_irq", 32'(timer_irq), 32'd0);
    chk("arst_cdata", 32'(console_data), 32'd0);
    rd(MB + 32'h18, v); chk("arst_drop", v, 32'd0);
    rd(MB + 32'h14, v); chk("arst_status", v, 32'h0000_0002);
    rd(32'h10, v); chk("arst_ram", v, 32'h1);
    #1 rst = 1'b1;
    step(2);
    chk("post_rst_valid", 32'(console_valid), 32'd0);
    rd(32'h10, v); chk("post_rst_ram", v, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_data_responder.md
Name: cpu_data_responder

Overview:
- Responder on the far side of the CPU core's data-memory port. Serves the core's load/store requests from a word-addressed data RAM and a small MMIO window.
- The MMIO window holds a 64-bit machine timer with compare interrupt, and a console TX FIFO drained over a valid/ready handshake.
- Sits at SoC top level beside the instruction memory, wired to the core's read_addr/rd_en/read_data and write_addr/wr_en/wr_data.

Parameters:
- DEPTH, 1024, data RAM size in 32-bit words (power of 2).
- FIFO_DEPTH, 16, console TX FIFO entries (power of 2, 2..256).
- PRESCALE, 1, clk cycles per mtime tick (>=1).
- MMIO_BASE, 32'hFFFF_0000, base address of the MMIO window (64 KiB window).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request this cycle.
- read_addr  in  32  load byte address; bits [1:0] ignored.
- read_data  out  32  load data, combinational, valid in the same cycle as rd_en.
- wr_en  in  1  store request this cycle.
- write_addr  in  32  store byte address; bits [1:0] ignored.
- wr_data  in  32  store data.
- console_valid  out  1  FIFO head byte available.
- console_data  out  8  FIFO head byte.
- console_ready  in  1  sink accepts the head byte.
- timer_irq  out  1  registered; high while mtime >= mtimecmp.

Behaviour:
- Address decode, per request:
  - RAM hit: addr < DEPTH*4; word index = addr[log2(DEPTH)+1:2].
  - MMIO hit: addr[31:16] == MMIO_BASE[31:16]; register offset = addr[7:0].
  - Everything else is unmapped: reads return 0, writes are ignored.
- Read path:
  - read_data = 0 when rd_en=0.
  - Zero-latency combinational read; the core samples it in the same cycle.
  - Read and write to the same location in the same cycle: the read returns the old value; the write commits at the edge.
  - rd_en and wr_en may be high together; both are serviced.
- MMIO map (offset, access, reset value):
  - 0x00 MTIME_LO, R/W, 0.
  - 0x04 MTIME_HI, R/W, 0.
  - 0x08 MTIMECMP_LO, R/W, 32'hFFFF_FFFF.
  - 0x0C MTIMECMP_HI, R/W, 32'hFFFF_FFFF.
  - 0x10 CONSOLE_TX, W; a write pushes wr_data[7:0]; reads return 0.
  - 0x14 STATUS, RO: bit0 fifo_full, bit1 fifo_empty, bit2 timer_irq, [15:8] fifo_count, rest 0. Reset value 32'h0000_0002.
  - 0x18 DROP_COUNT, RO, 0.
  - Writes to RO or unlisted offsets are ignored; reads of unlisted offsets return 0.
- Timer:
  - A prescaler counts 0..PRESCALE-1; mtime increments by 1 when it wraps.
  - Increment is 64-bit: MTIME_LO carry-out increments MTIME_HI; 2^64-1 wraps to 0.
  - A CPU write to MTIME_LO or MTIME_HI in a tick cycle wins: the written half takes wr_data, the other half holds, and there is no increment that cycle.
  - Prescaler resets to 0 on any MTIME write.
  - timer_irq <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values, one-cycle registered latency.
  - Writing MTIMECMP above mtime deasserts timer_irq on the following edge.
- Console FIFO:
  - Circular buffer with head/tail pointers and a count.
  - console_valid = !empty; console_data = head entry (show-ahead).
  - Pop occurs when console_valid && console_ready.
  - Push occurs on a CONSOLE_TX write when the FIFO is not full at the start of the cycle.
  - A push while full drops the byte and increments DROP_COUNT, saturating at 32'hFFFF_FFFF. This holds even if a pop happens in the same cycle.
  - Push and pop in the same non-full, non-empty cycle: count unchanged, both pointers advance.
  - Push when empty: no pop that cycle; console_valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset (rst=0, asynchronous):
  - Cleared: RAM contents are not cleared; mtime, prescaler, DROP_COUNT and FIFO pointers/count clear; MTIMECMP is set to all-ones.
  - Outputs: timer_irq=0, console_valid=0, console_data=0.
  - read_data follows its combinational rule (0 while rd_en=0).
  - Reset mid-drain discards FIFO contents.
- Release: normal operation from the first rising edge after rst goes high.

Optional Feature:
- Macro: CPU_DATA_RESPONDER_TIMER_EN.
- Defined: timer, prescaler, the four MTIME/MTIMECMP registers and timer_irq are as specified.
- Undefined:
  - No timer logic is synthesised.
  - Offsets 0x00-0x0C read 0 and ignore writes.
  - timer_irq is tied to 0; STATUS bit2 reads 0.
  - The RAM and console paths are unchanged.

Test Plan:
- RAM: write 32'hDEADBEEF to 0x0000_0010, then rd_en at 0x0000_0012 -> read_data=32'hDEADBEEF. Same-cycle read+write to 0x10 with 32'h1 -> read returns the old value 32'hDEADBEEF. Read 0x0001_0000 -> 0.
- Timer, PRESCALE=1: write MTIME_LO=32'hFFFF_FFFE, MTIME_HI=0; two cycles later -> MTIME_HI=1, MTIME_LO=0. Write MTIMECMP_HI=0, MTIMECMP_LO=5 with mtime=0 -> timer_irq rises on the edge after mtime reaches 5.
- FIFO fill: console_ready=0, write 'A'..'Q' (17 bytes) to CONSOLE_TX with FIFO_DEPTH=16 -> STATUS=32'h0000_1001, DROP_COUNT=1. Raise console_ready -> 'A'..'P' drained in order, one per cycle; console_valid then 0 and STATUS bit1=1.
- Simultaneous events: FIFO full and console_ready=1, push 'Z' -> 'Z' dropped, count 15, DROP_COUNT increments. FIFO holding 3 entries, push+pop same cycle -> count stays 3.
- Reset mid-operation: assert rst low asynchronously between edges with 5 bytes queued and timer_irq=1 -> console_valid, timer_irq and DROP_COUNT go to 0 immediately; STATUS reads 32'h0000_0002; a RAM word written before reset reads back intact.
- Macro undefined: read of MTIME_LO -> 0 after 100 cycles; timer_irq stays 0.
